// File: rtl/router_input_fifo.sv
// router_input_fifo: RTS/CTS receiver for one router input port; buffers flits for the N/E/W/S/L arbiters.
// Latency: CTS is registered one cycle after DRTS; a flit written at edge k shows on Data_out in cycle k+1.
// Backpressure: CTS is withheld while full, so upstream holds DRTS; optional sticky err flags via FIFO_ERR_DETECT_EN.
module router_input_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    localparam int PTR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] RX,
    input  logic                  DRTS,
    input  logic [4:0]            read_en,
    output logic                  CTS,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  empty,
    output logic                  full
`ifdef FIFO_ERR_DETECT_EN
    ,
    output logic [1:0]            err
`endif
);

    localparam logic [PTR_W-1:0] PTR_ONE = (PTR_W)'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      read_ptr;
    logic [PTR_W-1:0]      write_ptr;
    logic [PTR_W:0]        count;
    logic                  write;
    logic                  read;

    assign empty    = (count == '0);
    assign full     = (count == CNT_MAX);
    assign Data_out = mem[read_ptr];

    // A CTS pulse with DRTS dropped is simply lost; CTS is gated by full, so no write ever lands on a full buffer.
    assign write = DRTS & CTS;
    assign read  = (|read_en) & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            CTS       <= 1'b0;
            read_ptr  <= '0;
            write_ptr <= '0;
            count     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            CTS <= ~CTS & DRTS & ~full;
            if (write) begin
                mem[write_ptr] <= RX;
                write_ptr      <= write_ptr + PTR_ONE;
            end
            if (read) begin
                read_ptr <= read_ptr + PTR_ONE;
            end
            case ({write, read})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

`ifdef FIFO_ERR_DETECT_EN
    logic multi_rd;

    // Clearing the lowest set bit leaves something only if two or more bits were high.
    assign multi_rd = |(read_en & (read_en - 5'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 2'b00;
        end else begin
            if ((|read_en) && empty) begin
                err[0] <= 1'b1;
            end
            if (multi_rd) begin
                err[1] <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_router_input_fifo.sv
// Bench for router_input_fifo: upstream RTS/CTS driver, random arbiter reads, queue-based reference model.
module tb_router_input_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst;
    logic [DW-1:0] RX;
    logic          DRTS;
    logic [4:0]    read_en;
    logic          CTS;
    logic [DW-1:0] Data_out;
    logic          empty;
    logic          full;
`ifdef FIFO_ERR_DETECT_EN
    logic [1:0]    err;
`endif

    router_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .RX       (RX),
        .DRTS     (DRTS),
        .read_en  (read_en),
        .CTS      (CTS),
        .Data_out (Data_out),
        .empty    (empty),
        .full     (full)
`ifdef FIFO_ERR_DETECT_EN
        ,
        .err      (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Flits waiting to be offered upstream, and flits expected out of the buffer in order.
    logic [DW-1:0] send_q[$];
    logic [DW-1:0] exp_q[$];
    logic          rst_req       = 1'b0;
    logic          allow_withdraw = 1'b0;
    logic          hs            = 1'b0;

    initial begin
        rst     = 1'b0;
        DRTS    = 1'b0;
        RX      = '0;
        read_en = '0;
    end

    // Upstream arbiter: raises DRTS per flit, holds it until the CTS edge, optionally withdraws.
    always begin
        @(negedge clk);
        if (rst_req) begin
            rst     = 1'b1;
            DRTS    = 1'b0;
            hs      = 1'b0;
            rst_req = 1'b0;
            send_q.delete();
        end else begin
            rst = 1'b0;
            if (hs) begin
                DRTS = 1'b0;
                hs   = 1'b0;
            end
            if (!DRTS && send_q.size() != 0) begin
                RX   = send_q.pop_front();
                DRTS = 1'b1;
                exp_q.push_back(RX);
            end else if (DRTS && allow_withdraw && $urandom_range(0, 15) == 0) begin
                DRTS = 1'b0;
                void'(exp_q.pop_back());
            end
            if (DRTS && CTS) hs = 1'b1;
        end
    end

    // Reference model: occupancy count plus the expected-flit queue; CTS follows the handshake rule.
    int         m_cnt  = 0;
    logic       m_cts  = 1'b0;
    logic       m_ok   = 1'b0;
    logic       m_zero = 1'b0;
    logic [1:0] m_err  = 2'b00;
    logic       wr, rd, full_now;

    always begin
        @(negedge clk);
        #4;
        if (m_ok) begin
            chk("cts", 32'(CTS), 32'(m_cts));
            chk("empty", 32'(empty), 32'(m_cnt == 0));
            chk("full", 32'(full), 32'(m_cnt == DEPTH));
            if (m_cnt != 0 && exp_q.size() != 0) chk("data_out", Data_out, exp_q[0]);
            else if (m_cnt == 0 && m_zero) chk("data_out_cleared", Data_out, 32'h0);
`ifdef FIFO_ERR_DETECT_EN
            chk("err", 32'(err), 32'(m_err));
`endif
        end
        if (rst) begin
            m_ok   = 1'b1;
            m_cts  = 1'b0;
            m_cnt  = 0;
            m_err  = 2'b00;
            m_zero = 1'b1;
            exp_q.delete();
        end else if (m_ok) begin
            wr       = m_cts && DRTS;
            rd       = (read_en != 0) && (m_cnt != 0);
            full_now = (m_cnt == DEPTH);
            if (read_en != 0 && m_cnt == 0) m_err[0] = 1'b1;
            if ($countones(read_en) > 1) m_err[1] = 1'b1;
            if (rd && exp_q.size() != 0) void'(exp_q.pop_front());
            if (wr) m_zero = 1'b0;
            m_cnt = m_cnt + int'(wr) - int'(rd);
            m_cts = !m_cts && DRTS && !full_now;
        end
    end

    task automatic tick();
        @(negedge clk);
        #3;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        ticks(2);
    endtask

    logic [4:0] re;

    initial begin
        tick();
        do_reset();
        chk("reset_empty", 32'(empty), 32'h1);
        chk("reset_full", 32'(full), 32'h0);
        chk("reset_cts", 32'(CTS), 32'h0);
        chk("reset_data", Data_out, 32'h0);

        // First flit from reset: CTS in cycle 1, data visible after edge 2.
        send_q.push_back(32'hA5A5_0001);
        tick();
        tick();
        chk("first_cts", 32'(CTS), 32'h1);
        tick();
        chk("first_cts_drop", 32'(CTS), 32'h0);
        chk("first_not_empty", 32'(empty), 32'h0);
        chk("first_data", Data_out, 32'hA5A5_0001);

        // Fill to full with DRTS held; the fifth flit must wait.
        do_reset();
        for (int i = 1; i <= 5; i++) send_q.push_back(32'(i));
        ticks(12);
        chk("fill_full", 32'(full), 32'h1);
        chk("fill_head", Data_out, 32'h1);
        chk("fill_no_cts", 32'(CTS), 32'h0);

        // One read frees a slot; flit 5 wraps into slot 0; then drain.
        read_en = 5'b00001;
        tick();
        read_en = 5'b00000;
        chk("after_read_head", Data_out, 32'h2);
        chk("after_read_full", 32'(full), 32'h0);
        tick();
        chk("freed_cts", 32'(CTS), 32'h1);
        tick();
        chk("wrap_full", 32'(full), 32'h1);
        read_en = 5'b00001;
        ticks(4);
        read_en = 5'b00000;
        chk("drained_empty", 32'(empty), 32'h1);

        // Simultaneous read and write with two flits held.
        do_reset();
        send_q.push_back(32'h11);
        send_q.push_back(32'h22);
        ticks(6);
        send_q.push_back(32'h33);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (CTS) begin
                read_en = 5'b10000;
                tick();
                read_en = 5'b00000;
                break;
            end
        end
        chk("rw_head", Data_out, 32'h22);
        chk("rw_not_full", 32'(full), 32'h0);
        chk("rw_not_empty", 32'(empty), 32'h0);

        // Reset in the middle of a transfer.
        send_q.push_back(32'h44);
        send_q.push_back(32'h55);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (m_cnt == 3 && CTS) break;
        end
        do_reset();
        chk("midrst_cts", 32'(CTS), 32'h0);
        chk("midrst_empty", 32'(empty), 32'h1);
        chk("midrst_data", Data_out, 32'h0);
        send_q.push_back(32'h66);
        ticks(3);
        chk("restart_data", Data_out, 32'h66);

`ifdef FIFO_ERR_DETECT_EN
        do_reset();
        read_en = 5'b00100;
        tick();
        read_en = 5'b00000;
        chk("err_underflow", 32'(err), 32'h1);
        chk("err_uf_empty", 32'(empty), 32'h1);
        send_q.push_back(32'h77);
        ticks(4);
        read_en = 5'b00011;
        tick();
        read_en = 5'b00000;
        chk("err_multi", 32'(err), 32'h3);
        chk("err_multi_single_read", 32'(empty), 32'h1);
`endif

        // Randomized traffic with withdrawals and occasional resets.
        allow_withdraw = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (send_q.size() < 2 && $urandom_range(0, 2) != 0) send_q.push_back($urandom);
            re = 5'b00000;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: re = 5'b00000;
`ifdef FIFO_ERR_DETECT_EN
                9:          re = 5'($urandom_range(0, 31));
`endif
                default:    re = 5'(1 << $urandom_range(0, 4));
            endcase
            read_en = re;
            if ($urandom_range(0, 499) == 0) begin
                read_en = 5'b00000;
                do_reset();
            end else begin
                tick();
            end
        end
        read_en        = 5'b00000;
        allow_withdraw = 1'b0;
        ticks(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
